// File: rtl/fc_credit_gate.sv
// Transmit-side flow-control credit gate: tracks per-class UpdateFC limits and consumed credits.
// Optional stall counter output (stall_cnt_o) is built when FC_CREDIT_STALL_STATS_EN is defined.
module fc_credit_gate #(
  parameter int unsigned HDR_W  = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [135:0]      dllp_i,
  input  logic              dllp_valid_i,
  input  logic              is_updatefc_i,
  input  logic              tlp_req_valid_i,
  input  logic [1:0]        tlp_req_class_i,
  input  logic [DATA_W-1:0] tlp_req_data_i,
  output logic              tlp_grant_o,
  output logic              fc_init_done_o,
  output logic [1:0]        fc_state_o
`ifdef FC_CREDIT_STALL_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [HDR_W-1:0]  cl_hdr  [3];
  logic [HDR_W-1:0]  cc_hdr  [3];
  logic [DATA_W-1:0] cl_data [3];
  logic [DATA_W-1:0] cc_data [3];
  logic [2:0]        inf_hdr, inf_data, seen, seen_nxt;

  logic              upd;
  logic [1:0]        upd_cls;
  logic [HDR_W-1:0]  upd_hdr;
  logic [DATA_W-1:0] upd_data;
  logic [1:0]        req_idx;
  logic [HDR_W-1:0]  hdr_room;
  logic [DATA_W-1:0] data_room;
  logic              hdr_ok, data_ok, grant;
  logic              unused_dllp;

  assign upd_cls     = dllp_i[57:56];
  assign upd_hdr     = HDR_W'(dllp_i[55:48]);
  assign upd_data    = DATA_W'(dllp_i[43:32]);
  assign upd         = dllp_valid_i & is_updatefc_i & (upd_cls != 2'b11);
  assign unused_dllp = ^{dllp_i[135:58], dllp_i[47:44], dllp_i[31:0]};

  // Class 11 is never granted; remap its index so the credit lookup stays in range.
  assign req_idx   = (tlp_req_class_i == 2'b11) ? 2'd0 : tlp_req_class_i;
  assign hdr_room  = cl_hdr[req_idx] - (cc_hdr[req_idx] + HDR_W'(1));
  assign data_room = cl_data[req_idx] - (cc_data[req_idx] + tlp_req_data_i);

  always_comb begin
    seen_nxt    = seen;
    state_nxt   = state;
    hdr_ok      = 1'b0;
    data_ok     = 1'b0;
    grant       = 1'b0;
    if (state == ST_INIT && upd) seen_nxt[upd_cls] = 1'b1;
    case (state)
      ST_IDLE:   state_nxt = ST_INIT;
      ST_INIT:   if (&seen_nxt) state_nxt = ST_ACTIVE;
      ST_ACTIVE: state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_IDLE;
    endcase
    hdr_ok  = inf_hdr[req_idx] | (hdr_room <= HDR_HALF);
    data_ok = inf_data[req_idx] | (tlp_req_data_i == '0) | (data_room <= DATA_HALF);
    grant   = tlp_req_valid_i & (state == ST_ACTIVE) & (tlp_req_class_i != 2'b11)
              & hdr_ok & data_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      seen     <= '0;
      inf_hdr  <= '0;
      inf_data <= '0;
      for (int unsigned c = 0; c < 3; c++) begin
        cl_hdr[c]  <= '0;
        cc_hdr[c]  <= '0;
        cl_data[c] <= '0;
        cc_data[c] <= '0;
      end
    end else begin
      state <= state_nxt;
      seen  <= seen_nxt;
      for (int unsigned c = 0; c < 3; c++) begin
        // First UpdateFC of a class latches the infinite flags; later ones only refresh finite limits.
        if (upd && upd_cls == 2'(c)) begin
          if (state == ST_INIT && !seen[c]) begin
            cl_hdr[c]   <= upd_hdr;
            cl_data[c]  <= upd_data;
            inf_hdr[c]  <= (upd_hdr == '0);
            inf_data[c] <= (upd_data == '0);
          end else if (state != ST_IDLE) begin
            if (!inf_hdr[c])  cl_hdr[c]  <= upd_hdr;
            if (!inf_data[c]) cl_data[c] <= upd_data;
          end
        end
        if (grant && tlp_req_class_i == 2'(c)) begin
          cc_hdr[c]  <= cc_hdr[c] + HDR_W'(1);
          cc_data[c] <= cc_data[c] + tlp_req_data_i;
        end
      end
    end
  end

  assign tlp_grant_o    = grant;
  assign fc_init_done_o = (state == ST_ACTIVE);
  assign fc_state_o     = state;

`ifdef FC_CREDIT_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (tlp_req_valid_i && state == ST_ACTIVE && !grant && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fc_credit_gate.sv
// Directed self-checking bench for fc_credit_gate (init, credit limits, wrap, same-cycle update, reset).
module tb_fc_credit_gate;

  logic         clk;
  logic         rst;
  logic [135:0] dllp_i;
  logic         dllp_valid_i;
  logic         is_updatefc_i;
  logic         tlp_req_valid_i;
  logic [1:0]   tlp_req_class_i;
  logic [11:0]  tlp_req_data_i;
  logic         tlp_grant_o;
  logic         fc_init_done_o;
  logic [1:0]   fc_state_o;
`ifdef FC_CREDIT_STALL_STATS_EN
  logic [31:0]  stall_cnt_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_grant;

  fc_credit_gate #(.HDR_W(8), .DATA_W(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .dllp_i          (dllp_i),
    .dllp_valid_i    (dllp_valid_i),
    .is_updatefc_i   (is_updatefc_i),
    .tlp_req_valid_i (tlp_req_valid_i),
    .tlp_req_class_i (tlp_req_class_i),
    .tlp_req_data_i  (tlp_req_data_i),
    .tlp_grant_o     (tlp_grant_o),
    .fc_init_done_o  (fc_init_done_o),
    .fc_state_o      (fc_state_o)
`ifdef FC_CREDIT_STALL_STATS_EN
    ,
    .stall_cnt_o     (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] mk_dllp(input logic [1:0] c, input logic [7:0] h,
                                           input logic [11:0] d);
    logic [135:0] v;
    v          = '0;
    v[57:56]   = c;
    v[55:48]   = h;
    v[43:32]   = d;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle UpdateFC; the grant seen in that cycle is checked against exp_grant.
  task automatic send_upd(input string tag, input logic [1:0] c, input logic [7:0] h,
                          input logic [11:0] d, input logic exp_grant);
    dllp_i        = mk_dllp(c, h, d);
    dllp_valid_i  = 1'b1;
    is_updatefc_i = 1'b1;
    @(negedge clk);
    check(tag, 32'(tlp_grant_o), 32'(exp_grant));
    cyc();
    dllp_valid_i  = 1'b0;
    is_updatefc_i = 1'b0;
  endtask

  task automatic req_once(input string tag, input logic [1:0] c, input logic [11:0] d,
                          input logic exp_grant);
    tlp_req_valid_i = 1'b1;
    tlp_req_class_i = c;
    tlp_req_data_i  = d;
    @(negedge clk);
    check(tag, 32'(tlp_grant_o), 32'(exp_grant));
    cyc();
    tlp_req_valid_i = 1'b0;
  endtask

  // Holds the current request and counts grants until blocked (bounded).
  task automatic count_grants(output int unsigned n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!tlp_grant_o) break;
      n++;
      cyc();
    end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    dllp_i = '0; dllp_valid_i = 1'b0; is_updatefc_i = 1'b0;
    tlp_req_valid_i = 1'b0; tlp_req_class_i = 2'b00; tlp_req_data_i = '0;
    #12;
    check("rst_grant", 32'(tlp_grant_o), 32'd0);
    check("rst_done",  32'(fc_init_done_o), 32'd0);
    check("rst_state", 32'(fc_state_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("idle_to_init", 32'(fc_state_o), 32'd1);

    // Init sequence with an NP request pending throughout
    tlp_req_valid_i = 1'b1; tlp_req_class_i = 2'b01; tlp_req_data_i = 12'd5;
    send_upd("init_p_nogrant", 2'b00, 8'd4, 12'd16, 1'b0);
    send_upd("init_np_nogrant", 2'b01, 8'd2, 12'd0, 1'b0);
    dllp_i = mk_dllp(2'b10, 8'd0, 12'd0); dllp_valid_i = 1'b1; is_updatefc_i = 1'b0;
    cyc();
    dllp_valid_i = 1'b0;
    check("non_updatefc_ignored", 32'(fc_state_o), 32'd1);
    send_upd("init_cpl_nogrant", 2'b10, 8'd0, 12'd0, 1'b0);
    @(negedge clk);
    check("init_done", 32'(fc_init_done_o), 32'd1);
    check("active_state", 32'(fc_state_o), 32'd2);
    check("held_req_first_active", 32'(tlp_grant_o), 32'd1);
    cyc();
    tlp_req_valid_i = 1'b0;
    req_once("np_data_inf", 2'b01, 12'hFFF, 1'b1);
    req_once("np_hdr_limit", 2'b01, 12'd0, 1'b0);
    req_once("cpl_inf_a", 2'b10, 12'h800, 1'b1);
    req_once("cpl_inf_b", 2'b10, 12'hFFF, 1'b1);

    // Five back-to-back P requests of 4 data credits against limits 4/16
    tlp_req_valid_i = 1'b1; tlp_req_class_i = 2'b00; tlp_req_data_i = 12'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("p_burst_%0d", i), 32'(tlp_grant_o), (i < 4) ? 32'd1 : 32'd0);
      cyc();
    end
    send_upd("p_upd_old_cl", 2'b00, 8'd5, 12'd20, 1'b0);
    @(negedge clk);
    check("p_fifth_after_upd", 32'(tlp_grant_o), 32'd1);
    cyc();

    // Header counter wrap: drive CC_hdr to 0xFE, then limit 0x02
    tlp_req_data_i = 12'd0;
    send_upd("wrap_upd80", 2'b00, 8'h80, 12'd20, 1'b0);
    count_grants(n_grant);
    check("wrap_fill_80", n_grant, 32'd123);
    send_upd("wrap_updfe", 2'b00, 8'hFE, 12'd20, 1'b0);
    count_grants(n_grant);
    check("wrap_fill_fe", n_grant, 32'd126);
    send_upd("wrap_upd02", 2'b00, 8'h02, 12'd20, 1'b0);
    count_grants(n_grant);
    check("wrap_grants", n_grant, 32'd4);
    @(negedge clk);
    check("wrap_blocked", 32'(tlp_grant_o), 32'd0);

    // Same-cycle UpdateFC and grant: decision on old CL, both registers update
    cyc();
    dllp_i = mk_dllp(2'b00, 8'd3, 12'd20); dllp_valid_i = 1'b1; is_updatefc_i = 1'b1;
    @(negedge clk);
    check("same_cyc_old_block", 32'(tlp_grant_o), 32'd0);
    cyc();
    dllp_i = mk_dllp(2'b00, 8'd4, 12'd20);
    @(negedge clk);
    check("same_cyc_grant", 32'(tlp_grant_o), 32'd1);
    cyc();
    dllp_valid_i = 1'b0; is_updatefc_i = 1'b0;
    @(negedge clk);
    check("same_cyc_cl_loaded", 32'(tlp_grant_o), 32'd1);
    cyc();
    @(negedge clk);
    check("same_cyc_cc_incr", 32'(tlp_grant_o), 32'd0);
    cyc();
    tlp_req_valid_i = 1'b0;

    // Reset pulse with a grantable Cpl request pending
    tlp_req_valid_i = 1'b1; tlp_req_class_i = 2'b10; tlp_req_data_i = 12'd1;
    #2;
    check("pre_rst_grant", 32'(tlp_grant_o), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(tlp_grant_o), 32'd0);
    check("mid_rst_done",  32'(fc_init_done_o), 32'd0);
    check("mid_rst_state", 32'(fc_state_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef FC_CREDIT_STALL_STATS_EN
    check("stall_rst", stall_cnt_o, 32'd0);
`endif
    check("post_rst_idle_grant", 32'(tlp_grant_o), 32'd0);
    cyc();
    send_upd("reinit_p", 2'b00, 8'd1, 12'd1, 1'b0);
    send_upd("reinit_np", 2'b01, 8'd1, 12'd1, 1'b0);
    send_upd("reinit_cpl", 2'b10, 8'd1, 12'd1, 1'b0);
    @(negedge clk);
    check("reinit_done", 32'(fc_init_done_o), 32'd1);
    check("reinit_grant", 32'(tlp_grant_o), 32'd1);
    cyc();
    tlp_req_valid_i = 1'b0;

    // Reserved class requests are never granted
    tlp_req_valid_i = 1'b1; tlp_req_class_i = 2'b11; tlp_req_data_i = 12'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("cls11_%0d", i), 32'(tlp_grant_o), 32'd0);
      cyc();
    end
    tlp_req_valid_i = 1'b0;
`ifdef FC_CREDIT_STALL_STATS_EN
    check("stall_cls11", stall_cnt_o, 32'd3);
`endif
    req_once("cpl_finite_after_reinit", 2'b10, 12'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fc_credit_gate.md
Name: fc_credit_gate

Overview:
- Transmit-side flow-control credit gate. It sits directly downstream of the DLLP demultiplexer and consumes the UpdateFC indications it produces.
- Extracts the advertised header and data credit limits per class: Posted (P), Non-Posted (NP) and Completion (Cpl).
- Tracks credits consumed by outgoing TLPs and grants a TLP only when the receiver has enough credit.
- Runs the FC initialisation sequence before any grant is allowed.

Parameters:
- HDR_W, 8, width of the header credit limit and consumed counters (modulo 2^HDR_W).
- DATA_W, 12, width of the data credit limit and consumed counters (modulo 2^DATA_W).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- dllp_i  input  136  DLLP bus. Only [63:0] is used. Fields: [57:56] class (00=P, 01=NP, 10=Cpl, 11=reserved), [55:48] HdrFC, [43:32] DataFC.
- dllp_valid_i  input  1  dllp_i is valid this cycle.
- is_updatefc_i  input  1  demux classification: the current DLLP is an UpdateFC.
- tlp_req_valid_i  input  1  TX requests to send one TLP. Held until granted.
- tlp_req_class_i  input  2  class of the requested TLP.
- tlp_req_data_i  input  DATA_W  data credits the TLP needs (0 = no payload).
- tlp_grant_o  output  1  grant. Credits are consumed on the same edge.
- fc_init_done_o  output  1  all three classes initialised.
- fc_state_o  output  2  FSM state, for debug.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all CL (credit limit) and CC (credits consumed) registers = 0; infinite flags = 0; tlp_grant_o=0, fc_init_done_o=0, fc_state_o=0.
- An UpdateFC event is dllp_valid_i & is_updatefc_i with class != 11. Reserved class 11 is ignored.
- FSM states:
  - IDLE(0): advances to INIT on the first cycle after reset deasserts.
  - INIT(1): the first UpdateFC of each class loads that class's CL_hdr/CL_data and sets its seen bit. A field value of 0 in that first DLLP sets that field's infinite flag. Later UpdateFCs for an already-seen class overwrite CL (non-infinite fields only). INIT→ACTIVE on the edge where all 3 seen bits are set, including the edge that sets the last one.
  - ACTIVE(2): UpdateFC overwrites CL for non-infinite fields. No return to INIT except by reset.
- fc_init_done_o = (state==ACTIVE), registered.
- Grant check, combinational on current registers:
  - hdr_ok = inf_hdr | ((CL_hdr − (CC_hdr+1)) mod 2^HDR_W ≤ 2^(HDR_W−1)).
  - data_ok = inf_data | tlp_req_data_i==0 | ((CL_data − (CC_data+tlp_req_data_i)) mod 2^DATA_W ≤ 2^(DATA_W−1)).
  - tlp_grant_o = tlp_req_valid_i & ACTIVE & class!=11 & hdr_ok & data_ok.
- On grant: CC_hdr += 1 and CC_data += tlp_req_data_i, both modulo, for the requesting class only. Wrap-around is natural modulo arithmetic.
- A request with class 11 is never granted. The requester must drop it.
- Simultaneous UpdateFC and grant on the same class in one cycle: both apply (CL loads new value, CC increments). The grant decision uses the pre-edge CL.
- A request pending during INIT is held, not granted, and is granted in the first ACTIVE cycle if credit allows.
- Reset mid-operation clears all state immediately. A pending request is not granted until re-initialisation completes.

Optional Feature:
- Macro FC_CREDIT_STALL_STATS_EN.
- When defined: adds output stall_cnt_o (32 bits). It increments, saturating at 0xFFFF_FFFF, on every cycle where tlp_req_valid_i=1, state=ACTIVE and tlp_grant_o=0. Reset value 0.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset, then UpdateFC P(Hdr=4, Data=16), NP(2, 0), Cpl(0, 0) → fc_init_done_o=1 the cycle after the Cpl DLLP edge; NP data and Cpl hdr/data are infinite.
2. In ACTIVE, 5 back-to-back P requests with data=4 → first 4 granted (CC_hdr=4, CC_data=16); 5th stalls. Then UpdateFC P(Hdr=5, Data=20) → 5th granted the next cycle.
3. Wrap: P CL_hdr=0x02, CC_hdr=0xFE → 4 grants succeed (CC wraps to 0x02), 5th blocked.
4. Same-cycle UpdateFC(P) and P grant → CL updated and CC incremented in one edge; grant decided on the old CL.
5. Request issued during INIT, plus class-11 request in ACTIVE → the INIT request is granted only in the first ACTIVE cycle; the class-11 request is never granted. With FC_CREDIT_STALL_STATS_EN, stall_cnt_o counts the class-11 wait cycles.
6. rst pulse while a request is pending in ACTIVE → all outputs 0 immediately; no grant until three new UpdateFCs arrive.
